// File: rtl/fpu_sqrt_unit.sv
// Iterative IEEE-754 single-precision square root, round-to-nearest-even, fixed latency 26/BITS_PER_CYCLE+2.
// Optional feature macro FPU_SQRT_DENORM_EN: normalise denormal inputs instead of flushing them to signed zero.
module fpu_sqrt_unit #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        s_axis_a_tvalid,
   input  logic [31:0] s_axis_a_tdata,
   output logic        m_axis_result_tvalid,
   output logic [31:0] m_axis_result_tdata,
   output logic        busy
);

   localparam int          NITER = 26 / BITS_PER_CYCLE;
   localparam logic [4:0]  LAST  = 5'(NITER - 1);
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ITER, S_ROUND} state_t;

   state_t      r_state;
   logic [31:0] r_opnd;
   logic        r_spec;
   logic [31:0] r_spec_val;
   logic [7:0]  r_exp;
   logic [51:0] r_x;
   logic [25:0] r_q;
   logic [29:0] r_rem;
   logic [4:0]  r_cnt;

   logic        w_spec;
   logic [31:0] w_spec_val;
   logic [23:0] w_mant;
   logic [9:0]  w_eff_exp;
   logic [51:0] w_x_init;
   logic [7:0]  w_exp_init;
   logic [51:0] w_x;
   logic [25:0] w_q;
   logic [29:0] w_rem;
   logic [29:0] w_trial;
   logic [29:0] w_test;

   // Round-to-nearest-even on the 26-bit root; a carry out lands as an all-zero fraction with exponent+1.
   function automatic logic [31:0] round_pack(input logic [7:0] exp_in, input logic [25:0] q,
                                              input logic rem_nz);
      logic        rnd;
      logic        stk;
      logic        inc;
      logic [24:0] sig;
      rnd = q[1];
      stk = q[0] | rem_nz;
      inc = rnd & (stk | q[2]);
      sig = {1'b0, q[25:2]} + {24'h0, inc};
      return {1'b0, exp_in + {7'h0, sig[24]}, sig[22:0]};
   endfunction

`ifdef FPU_SQRT_DENORM_EN
   logic [4:0] w_lz;

   function automatic logic [4:0] clz24(input logic [23:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd24;
      found = 1'b0;
      for (int i = 23; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 5'(23 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction
`endif

   // Operand classification and radicand load for SETUP
   always_comb begin
      w_spec     = 1'b0;
      w_spec_val = 32'h0;
      w_mant     = {1'b1, r_opnd[22:0]};
      w_eff_exp  = {2'b00, r_opnd[30:23]};
`ifdef FPU_SQRT_DENORM_EN
      w_lz       = clz24({1'b0, r_opnd[22:0]});
`endif
      if (r_opnd[30:23] == 8'hFF) begin
         w_spec     = 1'b1;
         w_spec_val = ((r_opnd[22:0] != 23'h0) || r_opnd[31]) ? QNAN : 32'h7F80_0000;
      end else if (r_opnd[30:0] == 31'h0) begin
         w_spec     = 1'b1;
         w_spec_val = r_opnd;
      end else if (r_opnd[30:23] == 8'h00) begin
`ifdef FPU_SQRT_DENORM_EN
         if (r_opnd[31]) begin
            w_spec     = 1'b1;
            w_spec_val = QNAN;
         end else begin
            w_mant    = {1'b0, r_opnd[22:0]} << w_lz;
            w_eff_exp = 10'd1 - {5'h0, w_lz};
         end
`else
         w_spec     = 1'b1;
         w_spec_val = {r_opnd[31], 31'h0};
`endif
      end else if (r_opnd[31]) begin
         w_spec     = 1'b1;
         w_spec_val = QNAN;
      end
      w_x_init   = w_eff_exp[0] ? {1'b0, w_mant, 27'h0} : {w_mant, 28'h0};
      w_exp_init = 8'((w_eff_exp + (w_eff_exp[0] ? 10'd127 : 10'd126)) >> 1);
   end

   // Restoring square-root steps, BITS_PER_CYCLE root bits per clock
   always_comb begin
      w_x     = r_x;
      w_q     = r_q;
      w_rem   = r_rem;
      w_trial = 30'h0;
      w_test  = 30'h0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         w_trial = {w_rem[27:0], w_x[51:50]};
         w_test  = {2'b00, w_q, 2'b01};
         if (w_trial >= w_test) begin
            w_rem = w_trial - w_test;
            w_q   = {w_q[24:0], 1'b1};
         end else begin
            w_rem = w_trial;
            w_q   = {w_q[24:0], 1'b0};
         end
         w_x = {w_x[49:0], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state              <= S_IDLE;
         m_axis_result_tvalid <= 1'b0;
         m_axis_result_tdata  <= 32'h0;
         busy                 <= 1'b0;
      end else begin
         m_axis_result_tvalid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (s_axis_a_tvalid) begin
                  r_opnd  <= s_axis_a_tdata;
                  busy    <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_spec     <= w_spec;
               r_spec_val <= w_spec_val;
               r_exp      <= w_exp_init;
               r_x        <= w_x_init;
               r_q        <= 26'h0;
               r_rem      <= 30'h0;
               r_cnt      <= 5'h0;
               r_state    <= S_ITER;
            end
            S_ITER: begin
               r_x   <= w_x;
               r_q   <= w_q;
               r_rem <= w_rem;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == LAST) r_state <= S_ROUND;
            end
            S_ROUND: begin
               m_axis_result_tvalid <= 1'b1;
               m_axis_result_tdata  <= r_spec ? r_spec_val : round_pack(r_exp, r_q, r_rem != 30'h0);
               busy                 <= 1'b0;
               r_state              <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_sqrt_unit.sv
// Bench for fpu_sqrt_unit: directed cases plus random operands against a real-arithmetic sqrt model.
// Expectations for denormal inputs follow FPU_SQRT_DENORM_EN.
module tb_fpu_sqrt_unit;
   localparam int          LAT1 = 26 / 1 + 2;
   localparam int          LAT2 = 26 / 2 + 2;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        v1 = 1'b0, v2 = 1'b0;
   logic [31:0] d1 = 32'h0, d2 = 32'h0;
   logic        ov1, ov2, b1, b2;
   logic [31:0] od1, od2;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   fpu_sqrt_unit #(.BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .s_axis_a_tvalid(v1), .s_axis_a_tdata(d1),
      .m_axis_result_tvalid(ov1), .m_axis_result_tdata(od1), .busy(b1));

   fpu_sqrt_unit #(.BITS_PER_CYCLE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .s_axis_a_tvalid(v2), .s_axis_a_tdata(d2),
      .m_axis_result_tvalid(ov2), .m_axis_result_tdata(od2), .busy(b2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic drive(input int sel, input logic v, input logic [31:0] d);
      if (sel == 0) begin v1 = v; d1 = d; end
      else begin v2 = v; d2 = d; end
   endtask

   // Reference: IEEE double sqrt of the exact operand value, then RNE down to single precision.
   function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
      logic [7:0]  e;
      logic [22:0] f;
      real         v;
      real         r;
      logic [63:0] bits;
      logic [52:0] m;
      logic [24:0] keep;
      logic [28:0] rest;
      int          ee;
      int          se;
      e = a[30:23];
      f = a[22:0];
      if (e == 8'hFF) return (f != 23'h0 || a[31]) ? QNAN : 32'h7F80_0000;
      if (a[30:0] == 31'h0) return a;
      if (a[31]) begin
`ifdef FPU_SQRT_DENORM_EN
         return QNAN;
`else
         return (e == 8'h00) ? 32'h8000_0000 : QNAN;
`endif
      end
      if (e == 8'h00) begin
`ifdef FPU_SQRT_DENORM_EN
         v = real'(f) * $bitstoreal({1'b0, 11'(1023 - 149), 52'h0});
`else
         return 32'h0;
`endif
      end else begin
         ee = int'(e) - 127 + 1023;
         v  = $bitstoreal({1'b0, 11'(ee), f, 29'h0});
      end
      r    = $sqrt(v);
      bits = $realtobits(r);
      se   = int'(bits[62:52]) - 1023 + 127;
      m    = {1'b1, bits[51:0]};
      keep = {1'b0, m[52:29]};
      rest = m[28:0];
      if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
      if (keep[24]) begin
         se   = se + 1;
         keep = 25'h080_0000;
      end
      return {1'b0, 8'(se), keep[22:0]};
   endfunction

   function automatic logic [31:0] gen_operand();
      int k;
      k = $urandom_range(9, 0);
      if (k < 6)       return {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
      else if (k == 6) return $urandom;
      else if (k == 7) return {1'($urandom), 8'h00, 23'($urandom_range(8388607, 1))};
      else if (k == 8) return {1'b0, 8'($urandom_range(254, 1)), ($urandom_range(1, 0) == 1) ? 23'h7FFFFF : 23'h0};
      else             return {1'b1, 8'($urandom_range(254, 1)), 23'($urandom)};
   endfunction

   task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] expv, input string tag);
      int   cyc;
      logic got;
      logic bsy_ok;
      drive(sel, 1'b1, a);
      @(negedge clk);
      drive(sel, 1'b0, 32'h0);
      bsy_ok = (sel == 0) ? b1 : b2;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if ((sel == 0) ? ov1 : ov2) got = 1'b1;
         else if (!((sel == 0) ? b1 : b2)) bsy_ok = 1'b0;
      end
      chk({tag, ":lat"}, 32'(cyc), 32'((sel == 0) ? LAT1 : LAT2));
      chk({tag, ":data"}, (sel == 0) ? od1 : od2, expv);
      chk({tag, ":busy_res"}, {31'h0, (sel == 0) ? b1 : b2}, 32'h0);
      chk({tag, ":busy_fly"}, {31'h0, bsy_ok}, 32'h1);
   endtask

   initial begin
      int          npulse;
      int          c2;
      logic [31:0] r0, r1, a;

      repeat (3) @(negedge clk);
      chk("rst_tvalid", {31'h0, ov1}, 32'h0);
      chk("rst_tdata", od1, 32'h0);
      chk("rst_busy", {31'h0, b1}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(0, 32'h4080_0000, 32'h4000_0000, "sqrt4");
      run_op(0, 32'h4000_0000, 32'h3FB5_04F3, "sqrt2");
      run_op(0, 32'h3F80_0000, 32'h3F80_0000, "sqrt1");
      run_op(0, 32'h4110_0000, 32'h4040_0000, "sqrt9");
      @(negedge clk);
      chk("hold_tvalid", {31'h0, ov1}, 32'h0);
      chk("hold_tdata", od1, 32'h4040_0000);

      run_op(0, 32'hBF80_0000, QNAN, "neg1");
      run_op(0, 32'h8000_0000, 32'h8000_0000, "negzero");
      run_op(0, 32'h0000_0000, 32'h0000_0000, "poszero");
      run_op(0, 32'h7F80_0000, 32'h7F80_0000, "posinf");
      run_op(0, 32'hFF80_0000, QNAN, "neginf");
      run_op(0, 32'h7FC0_0001, QNAN, "nan");
`ifdef FPU_SQRT_DENORM_EN
      run_op(0, 32'h0000_0001, 32'h1A35_04F3, "denorm");
      run_op(0, 32'h8000_0001, QNAN, "negdenorm");
`else
      run_op(0, 32'h0000_0001, 32'h0000_0000, "denorm");
      run_op(0, 32'h8000_0001, 32'h8000_0000, "negdenorm");
`endif

      // Overlap: B dropped while busy, C accepted in A's result cycle
      drive(0, 1'b1, 32'h4080_0000);
      @(negedge clk);
      drive(0, 1'b0, 32'h0);
      npulse = 0;
      c2 = 0;
      r0 = 32'h0;
      r1 = 32'h0;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         drive(0, 1'b0, 32'h0);
         if (ov1) begin
            npulse++;
            if (npulse == 1) begin
               r0 = od1;
               drive(0, 1'b1, 32'h3F80_0000);
            end else begin
               r1 = od1;
               c2 = c;
            end
         end
         if (c == 9) drive(0, 1'b1, 32'h4110_0000);
      end
      chk("b2b_pulses", 32'(npulse), 32'd2);
      chk("b2b_first", r0, 32'h4000_0000);
      chk("b2b_second", r1, 32'h3F80_0000);
      chk("b2b_cycle", 32'(c2), 32'(2 * LAT1 + 1));

      // Reset in flight abandons the operation
      drive(0, 1'b1, 32'h4080_0000);
      @(negedge clk);
      drive(0, 1'b0, 32'h0);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst_tvalid", {31'h0, ov1}, 32'h0);
      chk("midrst_tdata", od1, 32'h0);
      chk("midrst_busy", {31'h0, b1}, 32'h0);
      npulse = 0;
      repeat (40) begin
         @(negedge clk);
         if (ov1) npulse++;
      end
      chk("midrst_nopulse", 32'(npulse), 32'd0);
      run_op(0, 32'h4000_0000, 32'h3FB5_04F3, "after_rst");

      run_op(1, 32'h4080_0000, 32'h4000_0000, "b2_sqrt4");
      run_op(1, 32'h4000_0000, 32'h3FB5_04F3, "b2_sqrt2");

      for (int i = 0; i < 150; i++) begin
         a = gen_operand();
         run_op(0, a, ref_sqrt(a), $sformatf("rand1_%h", a));
      end
      for (int i = 0; i < 40; i++) begin
         a = gen_operand();
         run_op(1, a, ref_sqrt(a), $sformatf("rand2_%h", a));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
